tt_rebot449_alu_sequencer: RTL and testbench

Byte-serial front end that sits directly upstream of the 8-bit ALU. It collects an instruction byte and two operand bytes over a narrow valid/ready input bus, then presents them to the ALU's combinational inputs. It captures the ALU result one cycle later and holds it on a valid/ready output port until it is consumed. This lets a pin-limited tile drive the ALU from an 8-bit input bus.

---
 rtl/tt_rebot449_alu_sequencer_if.sv | 29 ++
 rtl/tt_rebot449_alu_sequencer.sv | 106 ++++++++++
 tb/tb_tt_rebot449_alu_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tt_rebot449_alu_sequencer_if.sv
// Byte-serial input, ALU drive/return and result handshake bundle for the ALU sequencer.
// slave = sequencer side, master = the environment driving bytes and consuming results.
interface tt_rebot449_alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        alu_instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
  logic              illegal;
  logic              timeout;
  logic              busy;

  modport slave (
    input  in_data, in_valid, alu_result, result_ready,
    output in_ready, alu_instr, alu_a, alu_b, result, result_valid, illegal, timeout, busy
  );

  modport master (
    output in_data, in_valid, alu_result, result_ready,
    input  in_ready, alu_instr, alu_a, alu_b, result, result_valid, illegal, timeout, busy
  );
endinterface

// File: rtl/tt_rebot449_alu_sequencer.sv
// Collects instr/A/B bytes, drives the ALU, holds its result until consumed; result valid 1 edge after B,
// input stalls while a result is pending. Define ALU_SEQ_CHAIN_EN for accumulator chaining on instr bit 7.
module tt_rebot449_alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  tt_rebot449_alu_sequencer_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, DONE} state_t;

  state_t            state;
  logic [7:0]        instr;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt;

  logic accepting;
  logic xfer;
  logic to_hit;

  assign accepting = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign xfer      = bus.in_valid && accepting;
  // Abort on the cycle whose idle tick would bring the counter to TIMEOUT.
  assign to_hit    = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      instr     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            instr <= bus.in_data[7:0];
            cnt   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            if (bus.in_data[7]) begin
              a_q   <= result_q;
              state <= GET_B;
            end else begin
              state <= GET_A;
            end
`else
            state <= GET_A;
`endif
          end
        end
        GET_A, GET_B: begin
          if (xfer) begin
            cnt <= '0;
            if (state == GET_A) begin
              a_q   <= bus.in_data;
              state <= GET_B;
            end else begin
              b_q   <= bus.in_data;
              state <= EXEC;
            end
          end else if (to_hit) begin
            cnt       <= '0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          result_q  <= bus.alu_result;
          illegal_q <= (instr[2:0] >= 3'b110);
          state     <= DONE;
        end
        DONE: begin
          if (bus.result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rst_n && accepting;
  assign bus.result_valid = rst_n && (state == DONE);
  assign bus.alu_instr    = instr;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.result       = result_q;
  assign bus.illegal      = illegal_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_tt_rebot449_alu_sequencer.sv
// Directed bench for the ALU sequencer with a small reference ALU and a result scoreboard.
module tb_tt_rebot449_alu_sequencer;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_rebot449_alu_sequencer_if #(.DATA_W(DATA_W)) bus ();

  tt_rebot449_alu_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU: 0 and, 1 or, 2 xor, 3 sub, 4 add, 5 pass A, 6/7 zero.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_instr[2:0])
      3'd0: bus.alu_result = bus.alu_a & bus.alu_b;
      3'd1: bus.alu_result = bus.alu_a | bus.alu_b;
      3'd2: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'd3: bus.alu_result = bus.alu_a - bus.alu_b;
      3'd4: bus.alu_result = bus.alu_a + bus.alu_b;
      3'd5: bus.alu_result = bus.alu_a;
      default: bus.alu_result = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];   // {illegal, result}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {23'd0, bus.illegal, bus.result}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("sb_result", {24'd0, bus.result}, {24'd0, e[7:0]});
        chk("sb_illegal", {31'd0, bus.illegal}, {31'd0, e[8]});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset mid-GET_B
    send(8'h04);
    send(8'h33);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_instr", {24'd0, bus.alu_instr}, 32'd0);
    chk("rst_a", {24'd0, bus.alu_a}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_illegal_timeout", {30'd0, bus.illegal, bus.timeout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rel_busy", {31'd0, bus.busy}, 32'd0);

    // 2. ADD 0x25 + 0x17
    send(8'h04);
    send(8'h25);
    exp_q.push_back({1'b0, 8'h3C});
    send(8'h17);
    chk("add_a", {24'd0, bus.alu_a}, 32'h25);
    chk("add_b", {24'd0, bus.alu_b}, 32'h17);
    chk("add_exec_valid", {31'd0, bus.result_valid}, 32'd0);
    cyc();
    chk("add_valid", {31'd0, bus.result_valid}, 32'd1);
    chk("add_result", {24'd0, bus.result}, 32'h3C);
    chk("add_illegal", {31'd0, bus.illegal}, 32'd0);
    cyc();
    chk("add_idle", {31'd0, bus.busy}, 32'd0);

    // 3. Backpressure
    bus.result_ready = 1'b0;
    send(8'h04);
    send(8'h25);
    send(8'h17);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, bus.result_valid}, 32'd1);
      chk("bp_result", {24'd0, bus.result}, 32'h3C);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cyc();
    end
    exp_q.push_back({1'b0, 8'h3C});
    @(negedge clk) bus.result_ready = 1'b1;
    cyc();
    chk("bp_released", {30'd0, bus.busy, bus.result_valid}, 32'd0);
    chk("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // 4. Illegal opcode, then a legal SUB clears the flag
    send(8'h07);
    send(8'hAA);
    exp_q.push_back({1'b1, 8'h00});
    send(8'h55);
    repeat (2) cyc();
    chk("ill_hold_flag", {31'd0, bus.illegal}, 32'd1);
    chk("ill_hold_result", {24'd0, bus.result}, 32'h00);
    send(8'h03);
    send(8'h50);
    exp_q.push_back({1'b0, 8'h30});
    send(8'h20);
    repeat (2) cyc();
    chk("ill_cleared", {31'd0, bus.illegal}, 32'd0);

    // 5. Timeout abort, then a byte on the expiry cycle wins
    send(8'h00);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("to_pulse", {31'd0, bus.timeout}, {31'd0, i == 4});
      chk("to_busy", {31'd0, bus.busy}, {31'd0, i < 4});
    end
    cyc();
    chk("to_pulse_end", {31'd0, bus.timeout}, 32'd0);
    chk("to_a_kept", {24'd0, bus.alu_a}, 32'h50);
    chk("to_b_kept", {24'd0, bus.alu_b}, 32'h20);
    send(8'h00);
    repeat (3) cyc();
    send(8'h11);
    chk("to_win_pulse", {31'd0, bus.timeout}, 32'd0);
    chk("to_win_a", {24'd0, bus.alu_a}, 32'h11);
    chk("to_win_busy", {31'd0, bus.busy}, 32'd1);
    exp_q.push_back({1'b0, 8'h00});
    send(8'h22);
    repeat (2) cyc();

    // 6. Chain
    send(8'h04);
    send(8'h10);
    exp_q.push_back({1'b0, 8'h15});
    send(8'h05);
    repeat (2) cyc();
`ifdef ALU_SEQ_CHAIN_EN
    send(8'h84);
    chk("chain_a", {24'd0, bus.alu_a}, 32'h15);
    chk("chain_instr", {24'd0, bus.alu_instr}, 32'h84);
    exp_q.push_back({1'b0, 8'h16});
    send(8'h01);
`else
    send(8'h84);
    send(8'h01);
    cyc();
    chk("nochain_busy", {31'd0, bus.busy}, 32'd1);
    chk("nochain_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("nochain_a", {24'd0, bus.alu_a}, 32'h01);
    chk("nochain_valid", {31'd0, bus.result_valid}, 32'd0);
    exp_q.push_back({1'b0, 8'h03});
    send(8'h02);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
